load_store_unit: RTL and testbench

Load/store unit sitting between the sequential core's execute stage and `data_memory`. Accepts one RISC-V load or store per handshake, converts byte/half/word/doubleword accesses into the 64-bit word-wide `mem_read`/`mem_write` protocol, and returns the extended load data or a completion/error response. Sub-word stores use a two-cycle read-modify-write sequence, because the memory only writes whole 64-bit words.

---
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_store_unit : RISC-V B/H/W/D loads and stores over a 64-bit word port,   |
// |   read-modify-write for sub-word stores. Option macro: LSU_MISALIGN_CHECK_EN |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_read_data
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  logic [2:0]  state;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] word_q;
  logic [63:0] rdata_q;
  logic [2:0]  funct3_q;
  logic        write_q;
  logic        err_q;

  logic [2:0]  low_mask;
  logic        align_err;
  logic [63:0] req_addr_al;
  logic        req_err;
  logic [63:0] shifted;
  logic [63:0] load_ext;
  logic [7:0]  lane_sh;
  logic [63:0] byte_mask;
  logic [63:0] store_word;

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   low_mask = 3'b000;
      2'b01:   low_mask = 3'b001;
      2'b10:   low_mask = 3'b011;
      default: low_mask = 3'b111;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign align_err   = |(req_addr[2:0] & low_mask);
  assign req_addr_al = req_addr;
`else
  assign align_err   = 1'b0;
  assign req_addr_al = req_addr & ~{61'd0, low_mask};
`endif

  assign req_err = (req_funct3 == 3'b111) | (req_write & req_funct3[2])
                 | (req_addr >= 64'(MEM_BYTES)) | align_err;

  assign shifted = mem_read_data >> {addr_q[2:0], 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  load_ext = {56'd0, shifted[7:0]};
      3'b101:  load_ext = {48'd0, shifted[15:0]};
      3'b110:  load_ext = {32'd0, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  // Byte-lane merge; a doubleword is aligned so its mask covers the whole word.
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   lane_sh = 8'h01 << addr_q[2:0];
      2'b01:   lane_sh = 8'h03 << addr_q[2:0];
      2'b10:   lane_sh = 8'h0F << addr_q[2:0];
      default: lane_sh = 8'hFF;
    endcase
    byte_mask = '0;
    for (int i = 0; i < 8; i++) begin
      byte_mask[8*i +: 8] = {8{lane_sh[i]}};
    end
    store_word = (word_q & ~byte_mask)
               | ((wdata_q << {addr_q[2:0], 3'b000}) & byte_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      funct3_q <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr_al;
            funct3_q <= req_funct3;
            write_q  <= req_write;
            wdata_q  <= req_wdata;
            if (req_err) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state   <= RESP;
            end else if (!req_write) begin
              state <= LOAD;
            end else if (req_funct3[1:0] == 2'b11) begin
              state <= WRITE;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          rdata_q <= load_ext;
          err_q   <= 1'b0;
          state   <= RESP;
        end
        RMW_RD: begin
          word_q <= mem_read_data;
          state  <= WRITE;
        end
        WRITE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state   <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready      = (state == IDLE);
  assign resp_valid     = (state == RESP);
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign mem_read       = (state == LOAD) || (state == RMW_RD);
  assign mem_write      = (state == WRITE) && write_q;
  assign mem_address    = {addr_q[63:3], 3'b000};
  assign mem_write_data = mem_write ? store_word : 64'd0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// Scoreboard bench for load_store_unit with a behavioural 64-bit word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(8192)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  logic [63:0] mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [63:0] pl_val;

  assign mem_read_data = mem[mem_address[12:3]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[12:3]] <= mem_write_data;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
    logic [3:0]  lat;
    logic [3:0]  nrd;
    logic [3:0]  nwr;
  } resp_t;

  resp_t exp_q[$];
  resp_t obs_q[$];
  int vectors = 0;
  int miscompares = 0;
  int overlap = 0;

  function automatic resp_t mk(logic [63:0] rdata, logic err, int lat, int nrd, int nwr);
    resp_t r;
    r.rdata = rdata; r.err = err; r.lat = 4'(lat); r.nrd = 4'(nrd); r.nwr = 4'(nwr);
    return r;
  endfunction

  task automatic preload(input logic [9:0] idx, input logic [63:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Drives one request from IDLE and records what the unit returns.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input resp_t exp);
    resp_t o;
    bit got;
    exp_q.push_back(exp);
    o = '0;
    got = 0;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      if (mem_read)  o.nrd = o.nrd + 4'd1;
      if (mem_write) o.nwr = o.nwr + 4'd1;
      if (mem_read && mem_write) overlap++;
      if (resp_valid) begin
        o.rdata = resp_rdata; o.err = resp_err; o.lat = 4'(c); got = 1;
      end
      @(posedge clk); #1;
    end
    if (!got) o.lat = 4'hF;
    obs_q.push_back(o);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    #12;
    vectors++;
    if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 10000",
               {req_ready, resp_valid, resp_err, mem_read, mem_write});
    end
    vectors++;
    if ({resp_rdata, mem_address, mem_write_data} !== 192'd0) begin
      miscompares++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want all 0",
               resp_rdata, mem_address, mem_write_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got ready=%b valid=%b want 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_load_d;
    resp_t e, o;
    preload(10'd0, 64'd20);
    preload(10'd1023, 64'h8000_0000_0000_0001);
    issue(1'b0, 3'b011, 64'h0, 64'h0, mk(64'd20, 1'b0, 2, 1, 0));
    issue(1'b0, 3'b011, 64'h1FF8, 64'h0, mk(64'h8000_0000_0000_0001, 1'b0, 2, 1, 0));
    issue(1'b0, 3'b000, 64'h1FFF, 64'h0, mk(64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2, 1, 0));
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL load_d: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d want rdata=%h err=%b lat=%0d rd=%0d wr=%0d",
                 o.rdata, o.err, o.lat, o.nrd, o.nwr, e.rdata, e.err, e.lat, e.nrd, e.nwr);
      end
    end
  endtask

  task automatic test_store_byte;
    resp_t e, o;
    preload(10'd2, 64'h1122_3344_5566_7788);
    issue(1'b1, 3'b000, 64'h13, 64'hABCD_0080, mk(64'd0, 1'b0, 3, 1, 1));
    vectors++;
    if (mem[2] !== 64'h1122_3344_8066_7788) begin
      miscompares++;
      $display("FAIL sb_word: got %h want 1122334480667788", mem[2]);
    end
    issue(1'b0, 3'b000, 64'h13, 64'h0, mk(64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2, 1, 0));
    issue(1'b0, 3'b100, 64'h13, 64'h0, mk(64'h80, 1'b0, 2, 1, 0));
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL store_byte: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d want rdata=%h err=%b lat=%0d rd=%0d wr=%0d",
                 o.rdata, o.err, o.lat, o.nrd, o.nwr, e.rdata, e.err, e.lat, e.nrd, e.nwr);
      end
    end
  endtask

  task automatic test_store_word;
    resp_t e, o;
    preload(10'd4, 64'h0123_4567_89AB_CDEF);
    issue(1'b1, 3'b010, 64'h24, 64'h5555_5555_DEAD_BEEF, mk(64'd0, 1'b0, 3, 1, 1));
    issue(1'b0, 3'b010, 64'h24, 64'h0, mk(64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 2, 1, 0));
    issue(1'b0, 3'b110, 64'h24, 64'h0, mk(64'h0000_0000_DEAD_BEEF, 1'b0, 2, 1, 0));
    issue(1'b0, 3'b010, 64'h20, 64'h0, mk(64'hFFFF_FFFF_89AB_CDEF, 1'b0, 2, 1, 0));
    issue(1'b1, 3'b001, 64'h22, 64'h0000_1234, mk(64'd0, 1'b0, 3, 1, 1));
    issue(1'b0, 3'b011, 64'h20, 64'h0, mk(64'hDEAD_BEEF_1234_CDEF, 1'b0, 2, 1, 0));
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL store_word: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d want rdata=%h err=%b lat=%0d rd=%0d wr=%0d",
                 o.rdata, o.err, o.lat, o.nrd, o.nwr, e.rdata, e.err, e.lat, e.nrd, e.nwr);
      end
    end
  endtask

  task automatic test_misalign;
    resp_t e, o;
    preload(10'd6, 64'h0000_0000_A5B6_C7D8);
`ifdef LSU_MISALIGN_CHECK_EN
    issue(1'b0, 3'b001, 64'h33, 64'h0, mk(64'd0, 1'b1, 1, 0, 0));
`else
    issue(1'b0, 3'b001, 64'h33, 64'h0, mk(64'hFFFF_FFFF_FFFF_A5B6, 1'b0, 2, 1, 0));
`endif
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL misalign: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d want rdata=%h err=%b lat=%0d rd=%0d wr=%0d",
                 o.rdata, o.err, o.lat, o.nrd, o.nwr, e.rdata, e.err, e.lat, e.nrd, e.nwr);
      end
    end
  endtask

  task automatic test_errors;
    resp_t e, o;
    logic [2:0]  f3_t [4] = '{3'b111, 3'b100, 3'b011, 3'b011};
    logic        wr_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] ad_t [4] = '{64'h8, 64'h8, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF8};
    for (int i = 0; i < 4; i++) begin
      issue(wr_t[i], f3_t[i], ad_t[i], 64'hFFFF_FFFF_FFFF_FFFF, mk(64'd0, 1'b1, 1, 0, 0));
    end
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL errors: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d want rdata=%h err=%b lat=%0d rd=%0d wr=%0d",
                 o.rdata, o.err, o.lat, o.nrd, o.nwr, e.rdata, e.err, e.lat, e.nrd, e.nwr);
      end
    end
  endtask

  task automatic test_back_to_back;
    resp_t e, o;
    issue(1'b1, 3'b011, 64'h40, 64'hCAFE_BABE_1234_5678, mk(64'd0, 1'b0, 2, 0, 1));
    issue(1'b0, 3'b011, 64'h40, 64'h0, mk(64'hCAFE_BABE_1234_5678, 1'b0, 2, 1, 0));
    issue(1'b0, 3'b101, 64'h46, 64'h0, mk(64'h0000_0000_0000_CAFE, 1'b0, 2, 1, 0));
    issue(1'b0, 3'b001, 64'h44, 64'h0, mk(64'hFFFF_FFFF_FFFF_BABE, 1'b0, 2, 1, 0));
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL back_to_back: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d want rdata=%h err=%b lat=%0d rd=%0d wr=%0d",
                 o.rdata, o.err, o.lat, o.nrd, o.nwr, e.rdata, e.err, e.lat, e.nrd, e.nwr);
      end
    end
    vectors++;
    if (overlap !== 0) begin
      miscompares++;
      $display("FAIL strobe_overlap: got %0d cycles want 0", overlap);
    end
  endtask

  task automatic test_reset_mid_write;
    resp_t e, o;
    bit seen;
    preload(10'd9, 64'h5555_AAAA_0000_1111);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b011;
    req_addr = 64'h48; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if (mem_write !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre: got mem_write=%b want 1", mem_write);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_write !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_drop: got mem_write=%b ready=%b want 0 1", mem_write, req_ready);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    vectors++;
    if (seen !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_resp: got resp_seen=%b ready=%b want 0 1", seen, req_ready);
    end
    vectors++;
    if (mem[9] !== 64'h5555_AAAA_0000_1111) begin
      miscompares++;
      $display("FAIL abort_mem: got %h want 5555aaaa00001111", mem[9]);
    end
    @(posedge clk); #1;
    issue(1'b0, 3'b011, 64'h48, 64'h0, mk(64'h5555_AAAA_0000_1111, 1'b0, 2, 1, 0));
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL abort_reload: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d want rdata=%h err=%b lat=%0d rd=%0d wr=%0d",
                 o.rdata, o.err, o.lat, o.nrd, o.nwr, e.rdata, e.err, e.lat, e.nrd, e.nwr);
      end
    end
  endtask

  initial begin
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    test_reset();
    test_load_d();
    test_store_byte();
    test_store_word();
    test_misalign();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
